pe_inst_decode_stage: RTL and testbench
=======================================

Name: pe_inst_decode_stage

Overview:
- Registered instruction-decode stage for the PE core. Sits between the instruction fetch buffer and the PE execute unit.
- Splits each instruction word into opcode, function and immediate fields, classifies the opcode and flags illegal encodings.
- Uses a 2-entry valid/ready skid pipeline so both sides get full throughput and stall cleanly.
- Keeps saturating per-class statistics counters.

Parameters:
- INST_W, 32: instruction width in bits.
- OPC_W, 7: opcode field width, taken from the MSBs; must be >= 3.
- FUNC_W, 5: function field width, taken directly below the opcode.
- ARITH_FUNC_MAX, 8: ARITH func values 0..ARITH_FUNC_MAX-1 are legal.
- CNT_W, 16: statistics counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept an instruction
- in_inst  in  INST_W  instruction word
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  downstream accepts
- out_opcode  out  OPC_W  in_inst[INST_W-1 -: OPC_W]
- out_func  out  FUNC_W  in_inst[INST_W-OPC_W-1 -: FUNC_W]
- out_imm  out  INST_W-OPC_W-FUNC_W  remaining LSBs
- out_class  out  3  0 NOP, 1 ARITH, 2 LOGIC, 3 LOAD, 4 STORE, 7 ILLEGAL
- out_illegal  out  1  high when out_class==7
- cnt_clr  in  1  synchronous clear of all counters
- cnt_total  out  CNT_W  delivered instructions
- cnt_arith  out  CNT_W  delivered ARITH instructions
- cnt_illegal  out  CNT_W  delivered illegal instructions

Behaviour:
- Clock and reset: single clock domain, clk; rst is asynchronous and active-high.
- Opcode decode (values zero-extended to OPC_W):
  - 0 -> NOP
  - 1 -> ARITH
  - 2 -> LOGIC
  - 3 -> LOAD
  - 4 -> STORE
  - anything else -> ILLEGAL
- ARITH with func >= ARITH_FUNC_MAX -> class 7, illegal=1.
- Decode is computed at capture time. The stored fields are the registered decode result.
- Handshakes: accept = in_valid && in_ready; fire = out_valid && out_ready.
- State machine EMPTY / ONE / TWO (ONE = output register full; TWO = output and skid registers full):
  - EMPTY: accept -> ONE.
  - ONE: accept && !fire -> TWO (new word into skid). fire && !accept -> EMPTY. accept && fire -> ONE, output register reloaded with the new word.
  - TWO: fire -> ONE, skid moves into the output register. No accept is possible.
- in_ready is registered: next value = (next_state != TWO).
- out_valid = (state != EMPTY).
- Latency: an instruction accepted in cycle N is presented in cycle N+1.
- Throughput: 1 instruction/cycle while out_ready=1. Delivery is strictly in order; no drops, no duplicates.
- While out_valid && !out_ready, all out_* fields hold stable.
- Counters update on fire:
  - cnt_total increments on every fire.
  - cnt_arith increments when out_class==1.
  - cnt_illegal increments when out_illegal.
  - All counters saturate at 2^CNT_W-1.
  - cnt_clr takes priority over a same-cycle fire: result 0.
- Reset:
  - State -> EMPTY; in_ready=0, out_valid=0; all out fields and counters = 0; skid contents discarded.
  - in_ready rises on the first clk edge after rst deasserts.
  - Reset mid-operation drops any held instructions. Nothing is emitted afterwards until a new accept.

Test Plan:
- in_inst=32'h0210_0000, out_ready=1 -> next cycle: out_valid=1, out_opcode=7'b0000001, out_func=5'b00001, out_imm=0, out_class=1, out_illegal=0; cnt_total=1, cnt_arith=1.
- Backpressure: out_ready=0, offer A=0x0210_0000, B=0x0400_0000, C=0x0600_0000 back-to-back -> A and B accepted, in_ready=0 after B, out holds A. Release out_ready -> A, B, C emerge in order, no loss.
- in_inst opcode 7'h7F -> out_class=7, out_illegal=1, cnt_illegal=1. ARITH with func=5'd9 -> out_class=7, out_illegal=1.
- CNT_W=4, stream 20 ARITH at full rate -> cnt_arith=15, cnt_total=15 (saturated). cnt_clr pulsed together with a fire -> both counters read 0 next cycle.
- Reset asserted asynchronously while in state TWO -> out_valid=0, in_ready=0, counters 0 immediately. After release, in_ready=1 one edge later; no stale instruction appears.
- INST_W=64, OPC_W=8, FUNC_W=6, in_inst={8'd3,6'd5,50'h1234} -> out_class=3, out_func=5, out_imm=50'h1234.

Source files
------------

// File: rtl/pe_inst_decode_stage.sv
// Registered instruction decode with a 2-entry valid/ready skid and saturating stats counters.
// Accepted word appears on out_* the next cycle; in_ready is registered and drops only while both entries are full.
module pe_inst_decode_stage #(
  parameter int INST_W         = 32,
  parameter int OPC_W          = 7,
  parameter int FUNC_W         = 5,
  parameter int ARITH_FUNC_MAX = 8,
  parameter int CNT_W          = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [INST_W-1:0]                in_inst,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OPC_W-1:0]                 out_opcode,
  output logic [FUNC_W-1:0]                out_func,
  output logic [INST_W-OPC_W-FUNC_W-1:0]   out_imm,
  output logic [2:0]                       out_class,
  output logic                             out_illegal,
  input  logic                             cnt_clr,
  output logic [CNT_W-1:0]                 cnt_total,
  output logic [CNT_W-1:0]                 cnt_arith,
  output logic [CNT_W-1:0]                 cnt_illegal
);

  localparam int IMM_W = INST_W - OPC_W - FUNC_W;

  typedef struct packed {
    logic [OPC_W-1:0]  opc;
    logic [FUNC_W-1:0] func;
    logic [IMM_W-1:0]  imm;
    logic [2:0]        cls;
    logic              ill;
  } dec_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  dec_t             out_q, out_d;
  dec_t             skid_q, skid_d;
  dec_t             dec;
  logic [CNT_W-1:0] cnt_total_q, cnt_total_d;
  logic [CNT_W-1:0] cnt_arith_q, cnt_arith_d;
  logic [CNT_W-1:0] cnt_illegal_q, cnt_illegal_d;
  logic             accept, fire;

  assign accept = in_valid && in_ready_q;
  assign fire   = (state_q != EMPTY) && out_ready;

  always_comb begin
    dec      = '0;
    dec.opc  = in_inst[INST_W-1 -: OPC_W];
    dec.func = in_inst[INST_W-OPC_W-1 -: FUNC_W];
    dec.imm  = in_inst[IMM_W-1:0];
    if (dec.opc == OPC_W'(0))      dec.cls = 3'd0;
    else if (dec.opc == OPC_W'(1)) dec.cls = (32'(dec.func) < ARITH_FUNC_MAX) ? 3'd1 : 3'd7;
    else if (dec.opc == OPC_W'(2)) dec.cls = 3'd2;
    else if (dec.opc == OPC_W'(3)) dec.cls = 3'd3;
    else if (dec.opc == OPC_W'(4)) dec.cls = 3'd4;
    else                           dec.cls = 3'd7;
    dec.ill = (dec.cls == 3'd7);
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: if (accept) begin
        state_d = ONE;
        out_d   = dec;
      end
      ONE: begin
        if (accept && !fire) begin
          state_d = TWO;
          skid_d  = dec;
        end else if (accept && fire) begin
          out_d = dec;
        end else if (fire) begin
          state_d = EMPTY;
        end
      end
      TWO: if (fire) begin
        // in_ready is low here, so only the skid entry can move forward
        state_d = ONE;
        out_d   = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != TWO);
  end

  always_comb begin
    cnt_total_d   = cnt_total_q;
    cnt_arith_d   = cnt_arith_q;
    cnt_illegal_d = cnt_illegal_q;
    if (cnt_clr) begin
      cnt_total_d   = '0;
      cnt_arith_d   = '0;
      cnt_illegal_d = '0;
    end else if (fire) begin
      if (cnt_total_q != '1) cnt_total_d = cnt_total_q + CNT_W'(1);
      if (out_q.cls == 3'd1 && cnt_arith_q != '1) cnt_arith_d = cnt_arith_q + CNT_W'(1);
      if (out_q.ill && cnt_illegal_q != '1) cnt_illegal_d = cnt_illegal_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= EMPTY;
      in_ready_q    <= 1'b0;
      out_q         <= '0;
      skid_q        <= '0;
      cnt_total_q   <= '0;
      cnt_arith_q   <= '0;
      cnt_illegal_q <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      out_q         <= out_d;
      skid_q        <= skid_d;
      cnt_total_q   <= cnt_total_d;
      cnt_arith_q   <= cnt_arith_d;
      cnt_illegal_q <= cnt_illegal_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != EMPTY);
  assign out_opcode  = out_q.opc;
  assign out_func    = out_q.func;
  assign out_imm     = out_q.imm;
  assign out_class   = out_q.cls;
  assign out_illegal = out_q.ill;
  assign cnt_total   = cnt_total_q;
  assign cnt_arith   = cnt_arith_q;
  assign cnt_illegal = cnt_illegal_q;

endmodule

// File: tb/tb_pe_inst_decode_stage.sv
// Directed bench: default, narrow-counter and 64-bit-instruction configurations of the decode stage.
module tb_pe_inst_decode_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // default configuration
  logic        in_valid = 1'b0, out_ready = 1'b0, cnt_clr = 1'b0;
  logic [31:0] in_inst = '0;
  logic        in_ready, out_valid, out_illegal;
  logic [6:0]  out_opcode;
  logic [4:0]  out_func;
  logic [19:0] out_imm;
  logic [2:0]  out_class;
  logic [15:0] cnt_total, cnt_arith, cnt_illegal;

  pe_inst_decode_stage u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode), .out_func(out_func),
    .out_imm(out_imm), .out_class(out_class), .out_illegal(out_illegal), .cnt_clr(cnt_clr),
    .cnt_total(cnt_total), .cnt_arith(cnt_arith), .cnt_illegal(cnt_illegal)
  );

  // 4-bit counters for saturation
  logic        s_in_valid = 1'b0, s_out_ready = 1'b1, s_cnt_clr = 1'b0;
  logic [31:0] s_in_inst = '0;
  logic        s_in_ready, s_out_valid, s_out_illegal;
  logic [6:0]  s_out_opcode;
  logic [4:0]  s_out_func;
  logic [19:0] s_out_imm;
  logic [2:0]  s_out_class;
  logic [3:0]  s_cnt_total, s_cnt_arith, s_cnt_illegal;

  pe_inst_decode_stage #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_inst(s_in_inst),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_opcode(s_out_opcode), .out_func(s_out_func),
    .out_imm(s_out_imm), .out_class(s_out_class), .out_illegal(s_out_illegal), .cnt_clr(s_cnt_clr),
    .cnt_total(s_cnt_total), .cnt_arith(s_cnt_arith), .cnt_illegal(s_cnt_illegal)
  );

  // 64-bit instruction word
  logic        w_in_valid = 1'b0, w_out_ready = 1'b1, w_cnt_clr = 1'b0;
  logic [63:0] w_in_inst = '0;
  logic        w_in_ready, w_out_valid, w_out_illegal;
  logic [7:0]  w_out_opcode;
  logic [5:0]  w_out_func;
  logic [49:0] w_out_imm;
  logic [2:0]  w_out_class;
  logic [15:0] w_cnt_total, w_cnt_arith, w_cnt_illegal;

  pe_inst_decode_stage #(.INST_W(64), .OPC_W(8), .FUNC_W(6)) u_w64 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_inst(w_in_inst),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_opcode(w_out_opcode), .out_func(w_out_func),
    .out_imm(w_out_imm), .out_class(w_out_class), .out_illegal(w_out_illegal), .cnt_clr(w_cnt_clr),
    .cnt_total(w_cnt_total), .cnt_arith(w_cnt_arith), .cnt_illegal(w_cnt_illegal)
  );

  typedef struct {
    logic [31:0] inst;
    logic [6:0]  opc;
    logic [4:0]  func;
    logic [19:0] imm;
    logic [2:0]  cls;
    logic        ill;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{32'h0000_0000, 7'h00, 5'd0,  20'h00000, 3'd0, 1'b0};
    vt[1]  = '{32'h0210_0000, 7'h01, 5'd1,  20'h00000, 3'd1, 1'b0};
    vt[2]  = '{32'h0400_0000, 7'h02, 5'd0,  20'h00000, 3'd2, 1'b0};
    vt[3]  = '{32'h0600_0000, 7'h03, 5'd0,  20'h00000, 3'd3, 1'b0};
    vt[4]  = '{32'h0812_3456, 7'h04, 5'd1,  20'h23456, 3'd4, 1'b0};
    vt[5]  = '{32'hFE00_0000, 7'h7F, 5'd0,  20'h00000, 3'd7, 1'b1};
    vt[6]  = '{32'h0290_0000, 7'h01, 5'd9,  20'h00000, 3'd7, 1'b1};
    vt[7]  = '{32'h0270_0000, 7'h01, 5'd7,  20'h00000, 3'd1, 1'b0};
    vt[8]  = '{32'h0280_0000, 7'h01, 5'd8,  20'h00000, 3'd7, 1'b1};
    vt[9]  = '{32'h0A00_0000, 7'h05, 5'd0,  20'h00000, 3'd7, 1'b1};
    vt[10] = '{32'h05FF_FFFF, 7'h02, 5'd31, 20'hFFFFF, 3'd2, 1'b0};

    // reset state
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fields", 64'({out_opcode, out_func, out_imm, out_class, out_illegal}), 64'd0);
    chk("rst_cnts", 64'({cnt_total, cnt_arith, cnt_illegal}), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    chk("rel_in_ready_low", 64'(in_ready), 64'd0);
    tick();
    chk("rel_in_ready_high", 64'(in_ready), 64'd1);

    // single ARITH
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = 32'h0210_0000;
    tick();
    in_valid = 1'b0;
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_opc", 64'(out_opcode), 64'h01);
    chk("first_func", 64'(out_func), 64'h01);
    chk("first_imm", 64'(out_imm), 64'h0);
    chk("first_class", 64'(out_class), 64'd1);
    chk("first_ill", 64'(out_illegal), 64'd0);
    tick();
    chk("first_cnt_total", 64'(cnt_total), 64'd1);
    chk("first_cnt_arith", 64'(cnt_arith), 64'd1);
    chk("first_drained", 64'(out_valid), 64'd0);

    // table at full rate
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      in_inst  = vt[i].inst;
      tick();
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_ready", i), 64'(in_ready), 64'd1);
      chk($sformatf("v%0d_opc", i), 64'(out_opcode), 64'(vt[i].opc));
      chk($sformatf("v%0d_func", i), 64'(out_func), 64'(vt[i].func));
      chk($sformatf("v%0d_imm", i), 64'(out_imm), 64'(vt[i].imm));
      chk($sformatf("v%0d_class", i), 64'(out_class), 64'(vt[i].cls));
      chk($sformatf("v%0d_ill", i), 64'(out_illegal), 64'(vt[i].ill));
    end
    in_valid = 1'b0;
    tick();
    chk("tbl_drained", 64'(out_valid), 64'd0);
    chk("tbl_cnt_total", 64'(cnt_total), 64'd12);
    chk("tbl_cnt_arith", 64'(cnt_arith), 64'd3);
    chk("tbl_cnt_illegal", 64'(cnt_illegal), 64'd4);

    // backpressure: A, B accepted, C held off
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h0210_0000;
    tick();
    chk("bp_a_ready", 64'(in_ready), 64'd1);
    in_inst = 32'h0400_0000;
    tick();
    chk("bp_b_ready", 64'(in_ready), 64'd0);
    in_inst = 32'h0600_0000;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_hold%0d_opc", k), 64'(out_opcode), 64'h01);
      chk($sformatf("bp_hold%0d_func", k), 64'(out_func), 64'h01);
      chk($sformatf("bp_hold%0d_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp_hold%0d_ready", k), 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    chk("bp_a_out", 64'(out_opcode), 64'h01);
    tick();
    chk("bp_b_out", 64'(out_opcode), 64'h02);
    chk("bp_b_valid", 64'(out_valid), 64'd1);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_c_out", 64'(out_opcode), 64'h03);
    chk("bp_c_valid", 64'(out_valid), 64'd1);
    tick();
    chk("bp_drained", 64'(out_valid), 64'd0);
    chk("bp_cnt_total", 64'(cnt_total), 64'd15);

    // asynchronous reset while both entries are full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h0210_0000;
    tick();
    in_inst = 32'h0400_0000;
    tick();
    in_valid = 1'b0;
    chk("two_ready", 64'(in_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_cnts", 64'({cnt_total, cnt_arith, cnt_illegal}), 64'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("arst_rel_ready_low", 64'(in_ready), 64'd0);
    tick();
    chk("arst_rel_ready_high", 64'(in_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("arst_no_stale%0d", k), 64'(out_valid), 64'd0);
      tick();
    end
    chk("arst_cnt_total_after", 64'(cnt_total), 64'd0);

    // counter saturation with CNT_W=4
    s_in_valid = 1'b1;
    s_in_inst  = 32'h0210_0000;
    for (int k = 0; k < 20; k++) tick();
    s_in_valid = 1'b0;
    tick();
    chk("sat_drained", 64'(s_out_valid), 64'd0);
    chk("sat_cnt_arith", 64'(s_cnt_arith), 64'd15);
    chk("sat_cnt_total", 64'(s_cnt_total), 64'd15);
    chk("sat_cnt_illegal", 64'(s_cnt_illegal), 64'd0);
    s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    s_cnt_clr  = 1'b1;
    chk("clr_pre_valid", 64'(s_out_valid), 64'd1);
    tick();
    s_cnt_clr = 1'b0;
    chk("clr_cnt_total", 64'(s_cnt_total), 64'd0);
    chk("clr_cnt_arith", 64'(s_cnt_arith), 64'd0);
    chk("clr_fired", 64'(s_out_valid), 64'd0);

    // 64-bit instruction configuration
    w_in_valid = 1'b1;
    w_in_inst  = {8'd3, 6'd5, 50'h1234};
    tick();
    chk("w64_opc", 64'(w_out_opcode), 64'd3);
    chk("w64_class", 64'(w_out_class), 64'd3);
    chk("w64_func", 64'(w_out_func), 64'd5);
    chk("w64_imm", 64'(w_out_imm), 64'h1234);
    chk("w64_ill", 64'(w_out_illegal), 64'd0);
    w_in_inst = {8'd1, 6'd8, 50'h0};
    tick();
    w_in_valid = 1'b0;
    chk("w64_arith8_class", 64'(w_out_class), 64'd7);
    chk("w64_arith8_ill", 64'(w_out_illegal), 64'd1);
    tick();
    chk("w64_cnt_total", 64'(w_cnt_total), 64'd2);
    chk("w64_cnt_illegal", 64'(w_cnt_illegal), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
